// File: rtl/cactus_spawner.sv
// Obstacle field generator: four cactus slots scrolled one step per tick,
// spawned at LFSR-randomised gaps, with scroll speed rising every few spawns.
module cactus_spawner #(
  parameter int          STEP_DIV       = 100000,
  parameter int          TRAVEL_MAX     = 1224,
  parameter int          MIN_GAP        = 300,
  parameter int          GAP_MASK       = 255,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1,
  parameter int          SPEEDUP_SPAWNS = 8,
  parameter int          MAX_SPEED      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        game_over,
  output logic [11:0] cactuses0,
  output logic [11:0] cactuses1,
  output logic [11:0] cactuses2,
  output logic [11:0] cactuses3,
  output logic        cactus_sync,
  output logic [3:0]  active,
  output logic [2:0]  speed
);

  localparam int TICK_W  = $clog2(STEP_DIV + 1);
  localparam int SPAWN_W = $clog2(SPEEDUP_SPAWNS + 1);

  localparam logic [TICK_W-1:0]  TICK_LAST   = TICK_W'(STEP_DIV - 1);
  localparam logic [SPAWN_W-1:0] SPAWN_LAST  = SPAWN_W'(SPEEDUP_SPAWNS - 1);
  localparam logic [12:0]        TRAVEL_LIM  = 13'(TRAVEL_MAX);
  localparam logic [11:0]        MIN_GAP_V   = 12'(MIN_GAP);
  localparam logic [11:0]        GAP_MASK_V  = 12'(GAP_MASK);
  localparam logic [2:0]         MAX_SPEED_V = 3'(MAX_SPEED);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FROZEN
  } state_e;

  state_e              state_q, state_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [SPAWN_W-1:0]  spawns_q, spawns_d;
  logic [11:0]         gap_q, gap_d;
  logic [11:0]         target_q, target_d;
  logic [15:0]         lfsr_q, lfsr_d;
  logic [3:0][11:0]    pos_q, pos_d;
  logic [3:0]          active_q, active_d;
  logic [2:0]          speed_q, speed_d;
  logic                sync_q, sync_d;

  logic [12:0]         pos_sum;
  logic [12:0]         gap_sum;
  logic                spawn_done;

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    spawns_d   = spawns_q;
    gap_d      = gap_q;
    target_d   = target_q;
    pos_d      = pos_q;
    active_d   = active_q;
    speed_d    = speed_q;
    sync_d     = 1'b0;
    pos_sum    = '0;
    gap_sum    = '0;
    spawn_done = 1'b0;
    // Galois form, polynomial x^16+x^14+x^13+x^11; free-runs in every state
    lfsr_d     = {1'b0, lfsr_q[15:1]} ^ ({16{lfsr_q[0]}} & 16'hB400);

    case (state_q)
      ST_IDLE: begin
        if (!game_over) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (game_over) begin
          state_d = ST_FROZEN;
        end else if (tick_q == TICK_LAST) begin
          tick_d = '0;
          sync_d = 1'b1;
          for (int i = 0; i < 4; i++) begin
            pos_sum = {1'b0, pos_q[i]} + {10'd0, speed_q};
            if (active_q[i]) begin
              if (pos_sum >= TRAVEL_LIM) begin
                pos_d[i]    = '0;
                active_d[i] = 1'b0;
              end else begin
                pos_d[i] = pos_sum[11:0];
              end
            end
          end
          gap_sum = {1'b0, gap_q} + {10'd0, speed_q};
          gap_d   = gap_sum[12] ? 12'hFFF : gap_sum[11:0];
          // Spawn sees this tick's frees, so a just-vacated slot is reusable
          if (gap_d >= target_q) begin
            for (int i = 0; i < 4; i++) begin
              if (!spawn_done && !active_d[i]) begin
                active_d[i] = 1'b1;
                pos_d[i]    = '0;
                spawn_done  = 1'b1;
              end
            end
            if (spawn_done) begin
              gap_d    = '0;
              target_d = MIN_GAP_V + (lfsr_q[11:0] & GAP_MASK_V);
              if (spawns_q == SPAWN_LAST) begin
                spawns_d = '0;
                if (speed_q < MAX_SPEED_V) speed_d = speed_q + 3'd1;
              end else begin
                spawns_d = spawns_q + 1'b1;
              end
            end
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      ST_FROZEN: begin
        if (!game_over) begin
          state_d  = ST_RUN;
          pos_d    = '0;
          active_d = '0;
          speed_d  = 3'd1;
          gap_d    = '0;
          spawns_d = '0;
          tick_d   = '0;
          target_d = MIN_GAP_V + (lfsr_q[11:0] & GAP_MASK_V);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      tick_q   <= '0;
      spawns_q <= '0;
      gap_q    <= '0;
      target_q <= MIN_GAP_V;
      lfsr_q   <= LFSR_SEED;
      pos_q    <= '0;
      active_q <= '0;
      speed_q  <= 3'd1;
      sync_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      spawns_q <= spawns_d;
      gap_q    <= gap_d;
      target_q <= target_d;
      lfsr_q   <= lfsr_d;
      pos_q    <= pos_d;
      active_q <= active_d;
      speed_q  <= speed_d;
      sync_q   <= sync_d;
    end
  end

  assign cactuses0   = pos_q[0];
  assign cactuses1   = pos_q[1];
  assign cactuses2   = pos_q[2];
  assign cactuses3   = pos_q[3];
  assign active      = active_q;
  assign speed       = speed_q;
  assign cactus_sync = sync_q;

endmodule
